// File: rtl/jk_ctrl_pkg.sv
// Shared constants for the JK-cell counter controller: FSM states and per-bit
// {J,K} excitation codes.
package jk_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell with asynchronous active-high reset (Q -> 0).
module jk_cell
    import jk_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    logic r_q;

    // Standard JK table: hold, reset, set, toggle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:   r_q <= r_q;
                JK_RESET:  r_q <= 1'b0;
                JK_SET:    r_q <= 1'b1;
                JK_TOGGLE: r_q <= ~r_q;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign q  = r_q;
    assign qn = ~r_q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Programmable mod-MODULUS up/down counter built from a bank of JK cells.
// The controller only computes per-bit J/K excitation; the cells hold the count.
// Optional build macro JK_CTRL_ONESHOT_EN: stop at terminal count instead of
// wrapping, and pulse `done` for one cycle afterwards.
module jk_counter_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               up,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   count,
    output logic               running,
    output logic               tc,
    output logic [2*WIDTH-1:0] jk_code
`ifdef JK_CTRL_ONESHOT_EN
    ,
    output logic               done
`endif
);

    // Compared at WIDTH+1 bits so MODULUS == 2**WIDTH stays representable.
    localparam logic [WIDTH:0] LP_MAX = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] LP_MOD = (WIDTH+1)'(MODULUS);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_qn;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_at_max;
    logic             w_at_zero;
`ifdef JK_CTRL_ONESHOT_EN
    logic             w_done_next;
    logic             r_done;
`endif

    assign running   = (r_state == ST_RUN);
    assign w_at_max  = ({1'b0, count} == LP_MAX);
    assign w_at_zero = (count == '0);
    assign tc        = running & ((up & w_at_max) | (~up & w_at_zero));

    // Next FSM state and target count value.
    always_comb begin
        w_state_next = r_state;
        w_next       = count;
`ifdef JK_CTRL_ONESHOT_EN
        w_done_next  = 1'b0;
`endif
        // While reset is held, issue no excitation so jk_code reads all hold.
        if (!reset) begin
            case (r_state)
                ST_IDLE: if (start && !stop) w_state_next = ST_RUN;
                ST_RUN:  if (stop)           w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase

            if (load) begin
                if ({1'b0, load_val} >= LP_MOD) begin
                    w_next = LP_MAX[WIDTH-1:0];
                end else begin
                    w_next = load_val;
                end
            end else if (r_state == ST_RUN && !stop) begin
                if (up) begin
                    w_next = w_at_max ? '0 : count + WIDTH'(1);
                end else begin
                    w_next = w_at_zero ? LP_MAX[WIDTH-1:0] : count - WIDTH'(1);
                end
`ifdef JK_CTRL_ONESHOT_EN
                // One-shot: terminal count holds and drops back to idle.
                if (tc) begin
                    w_next       = count;
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
`endif
            end
        end
    end

    // Per-bit excitation: set where a 0 must become 1, reset where 1 must become 0.
    always_comb begin
        jk_code = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_j[i] = w_next[i] & w_qn[i];
            w_k[i] = ~w_next[i] & count[i];
            jk_code[2*i +: 2] = {w_j[i], w_k[i]};
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef JK_CTRL_ONESHOT_EN
    // One-cycle pulse following the terminal-count stop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_next;
        end
    end

    assign done = r_done;
`endif

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
        jk_cell u_cell (
            .clock (clock),
            .reset (reset),
            .j     (w_j[g]),
            .k     (w_k[g]),
            .q     (count[g]),
            .qn    (w_qn[g])
        );
    end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Self-checking bench for jk_counter_ctrl (WIDTH=4, MODULUS=10): vector table,
// directed corner sequences and random stimulus against an arithmetic model.
module tb_jk_counter_ctrl;

    localparam int W = 4;
    localparam int M = 10;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           stop  = 1'b0;
    logic           up    = 1'b0;
    logic           load  = 1'b0;
    logic [W-1:0]   load_val = '0;
    logic [W-1:0]   count;
    logic           running;
    logic           tc;
    logic [2*W-1:0] jk_code;
`ifdef JK_CTRL_ONESHOT_EN
    logic           done;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_count = 0;
    bit m_run   = 0;
    bit m_done  = 0;

    always #5 clock = ~clock;

    jk_counter_ctrl #(
        .WIDTH   (W),
        .MODULUS (M)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .running  (running),
        .tc       (tc),
        .jk_code  (jk_code)
`ifdef JK_CTRL_ONESHOT_EN
        ,
        .done     (done)
`endif
    );

    typedef struct {
        bit       st;
        bit       sp;
        bit       u;
        bit       ld;
        bit [3:0] lv;
        bit [3:0] exp_count;
        bit       exp_run;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit st, input bit sp, input bit u, input bit ld,
                          input logic [3:0] lv);
        start = st; stop = sp; up = u; load = ld; load_val = lv;
    endtask

    // Drive one cycle, compare all outputs against the model, advance both.
    task automatic apply(input bit st, input bit sp, input bit u, input bit ld,
                         input logic [3:0] lv);
        int n;
        bit nr;
        bit nd;
        bit exp_tc;
        logic [2*W-1:0] exp_jk;
        set_in(st, sp, u, ld, lv);
        #2;
        exp_tc = m_run && ((u && m_count == M - 1) || (!u && m_count == 0));
        nr = m_run;
        nd = 0;
        if (!m_run) begin
            if (st && !sp) nr = 1;
        end else if (sp) begin
            nr = 0;
        end
        if (ld) begin
            n = (int'(lv) >= M) ? M - 1 : int'(lv);
        end else if (m_run && !sp) begin
            n = u ? (m_count + 1) % M : (m_count + M - 1) % M;
`ifdef JK_CTRL_ONESHOT_EN
            if (exp_tc) begin
                n = m_count; nr = 0; nd = 1;
            end
`endif
        end else begin
            n = m_count;
        end
        exp_jk = '0;
        for (int b = 0; b < W; b++) begin
            bit nb;
            bit cb;
            nb = ((n >> b) & 1) != 0;
            cb = ((m_count >> b) & 1) != 0;
            if (nb != cb) exp_jk[2*b +: 2] = nb ? 2'b10 : 2'b01;
        end
        check("count", 32'(count), 32'(m_count));
        check("running", 32'(running), 32'(m_run));
        check("tc", 32'(tc), 32'(exp_tc));
        check("jk_code", 32'(jk_code), 32'(exp_jk));
`ifdef JK_CTRL_ONESHOT_EN
        check("done", 32'(done), 32'(m_done));
`endif
        @(posedge clock);
        #1;
        m_count = n;
        m_run   = nr;
        m_done  = nd;
    endtask

    // Assert reset between edges, check immediate effect, release at negedge.
    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        check({name, "_count"}, 32'(count), 0);
        check({name, "_running"}, 32'(running), 0);
        check({name, "_tc"}, 32'(tc), 0);
        check({name, "_jk"}, 32'(jk_code), 0);
        set_in(0, 0, 0, 0, 4'd0);
        @(negedge clock);
        reset = 1'b0;
        m_count = 0; m_run = 0; m_done = 0;
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        //           st sp u  ld lv  cnt run
        vecs[0]  = '{1, 0, 1, 0, 0,  0, 1};
        vecs[1]  = '{0, 0, 1, 0, 0,  1, 1};
        vecs[2]  = '{0, 0, 1, 1, 13, 9, 1};
        vecs[3]  = '{0, 0, 0, 0, 0,  8, 1};
        vecs[4]  = '{0, 0, 0, 0, 0,  7, 1};
        vecs[5]  = '{0, 1, 0, 0, 0,  7, 0};
        vecs[6]  = '{1, 1, 1, 0, 0,  7, 0};
        vecs[7]  = '{1, 0, 0, 1, 3,  3, 1};
        vecs[8]  = '{0, 0, 0, 0, 0,  2, 1};
        vecs[9]  = '{0, 1, 1, 1, 5,  5, 0};
        vecs[10] = '{0, 0, 1, 0, 0,  5, 0};
        vecs[11] = '{0, 0, 1, 1, 10, 9, 0};

        do_reset("init");

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].st, vecs[i].sp, vecs[i].u, vecs[i].ld, vecs[i].lv);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].exp_run));
        end

`ifndef JK_CTRL_ONESHOT_EN
        // Up wrap from 0 for 12 steps.
        do_reset("rst_wrap");
        apply(1, 0, 1, 0, 4'd0);
        for (int k = 1; k <= 12; k++) begin
            set_in(0, 0, 1, 0, 4'd0);
            #2;
            check("wrap_tc", 32'(tc), 32'(((k - 1) % 10) == 9));
            if (((k - 1) % 10) == 9) check("wrap_jk_bit0", 32'(jk_code[1:0]), 32'(2'b01));
            apply(0, 0, 1, 0, 4'd0);
            check("wrap_count", 32'(count), 32'(k % 10));
        end

        // Down wrap from 0.
        apply(1, 1, 0, 1, 4'd0);
        apply(1, 0, 0, 1, 4'd0);
        check("down_start_count", 32'(count), 0);
        set_in(0, 0, 0, 0, 4'd0);
        #2;
        check("down_tc_at0", 32'(tc), 1);
        apply(0, 0, 0, 0, 4'd0);
        check("down_9", 32'(count), 9);
        check("down_tc_at9", 32'(tc), 0);
        apply(0, 0, 0, 0, 4'd0);
        check("down_8", 32'(count), 8);
        apply(0, 0, 0, 0, 4'd0);
        check("down_7", 32'(count), 7);
`endif

        // Reset mid-RUN at count 7, between edges.
        apply(1, 0, 1, 1, 4'd7);
        check("pre_rst_count", 32'(count), 7);
        check("pre_rst_run", 32'(running), 1);
        #2;
        do_reset("rst_midrun");

        // Load saturation with stop in RUN, then hold.
        apply(1, 0, 1, 0, 4'd0);
        apply(0, 1, 1, 1, 4'd13);
        check("sat_count", 32'(count), 9);
        check("sat_running", 32'(running), 0);
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 1, 0, 4'd0);
            #2;
            check("hold_jk", 32'(jk_code), 0);
            apply(0, 0, 1, 0, 4'd0);
            check("hold_count", 32'(count), 9);
        end

        // start+stop together in IDLE, then start alone.
        apply(1, 1, 0, 0, 4'd0);
        check("ss_running", 32'(running), 0);
        check("ss_count", 32'(count), 9);
        apply(1, 0, 0, 0, 4'd0);
        check("st_running", 32'(running), 1);
        check("st_count", 32'(count), 9);
        apply(0, 0, 0, 0, 4'd0);
        check("st_first_step", 32'(count), 8);

`ifdef JK_CTRL_ONESHOT_EN
        // One-shot stop at terminal count.
        apply(0, 1, 1, 0, 4'd0);
        apply(1, 0, 1, 1, 4'd7);
        apply(0, 0, 1, 0, 4'd0);
        check("os_8", 32'(count), 8);
        apply(0, 0, 1, 0, 4'd0);
        check("os_9", 32'(count), 9);
        apply(0, 0, 1, 0, 4'd0);
        check("os_hold", 32'(count), 9);
        check("os_running", 32'(running), 0);
        check("os_done", 32'(done), 1);
        apply(0, 0, 1, 0, 4'd0);
        check("os_done_off", 32'(done), 0);
        // Load at terminal count takes priority.
        apply(1, 0, 1, 1, 4'd7);
        apply(0, 0, 1, 0, 4'd0);
        apply(0, 0, 1, 0, 4'd0);
        apply(0, 0, 1, 1, 4'd2);
        check("osl_count", 32'(count), 2);
        check("osl_running", 32'(running), 1);
        check("osl_done", 32'(done), 0);
`endif

        // Random stimulus against the model.
        for (int r = 0; r < 400; r++) begin
            apply($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                  4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
